multicycle_controller: RTL and testbench

Multicycle MIPS control unit replacing the single-cycle main decoder. A Moore state machine sequences each instruction over 3–5 cycles, driving the datapath enables and mux selects from the 6-bit opcode. It adds:
- memory-ready stalls for variable-latency memory
- optional ADDI and J support
- illegal-opcode detection
- a retired-instruction counter

It sits between the instruction register and the shared-memory multicycle datapath.

---
 rtl/multicycle_controller.sv | 138 +++++++++++++
 tb/tb_multicycle_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences each instruction over 3-5 cycles with
// memory-ready stalls, illegal-opcode trap and a retired-instruction counter.
module multicycle_controller #(
    parameter int OP_WIDTH     = 6,
    parameter int SUPPORT_ADDI = 1,
    parameter int SUPPORT_JUMP = 1,
    parameter int MEM_WAIT     = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_WIDTH-1:0]  Op,
    input  logic                 memReady,
    output logic                 pcWrite,
    output logic                 irWrite,
    output logic                 memWrite,
    output logic                 regWrite,
    output logic                 branch,
    output logic                 iorD,
    output logic                 regDst,
    output logic                 memToReg,
    output logic                 aluSrcA,
    output logic [1:0]           aluSrcB,
    output logic [1:0]           pcSrc,
    output logic [1:0]           aluOp,
    output logic [3:0]           state,
    output logic                 illegalOp,
    output logic                 instrDone,
    output logic [CNT_WIDTH-1:0] instrCount
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
        BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11,
        ILLEGAL = 4'd12
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       pcWrite;
        logic       memWrite;
        logic       regWrite;
        logic       branch;
        logic       done;
        logic       iorD;
        logic       regDst;
        logic       memToReg;
        logic       aluSrcA;
        logic       illegalOp;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic [1:0] aluOp;
    } ctl_t;

    state_t      st, nxt;
    ctl_t        ctl;
    logic        mr;
    logic [5:0]  op6;

    assign mr  = (MEM_WAIT != 0) ? memReady : 1'b1;
    assign op6 = Op[5:0];

    // Per-state control word; memReady-dependent terms are gated at the outputs.
    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.fetch = 1'b1; c.aluSrcB = 2'b01; end
            DECODE:   c.aluSrcB = 2'b11;
            MEMADR:   begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            MEMREAD:  c.iorD = 1'b1;
            MEMWB:    begin c.memToReg = 1'b1; c.regWrite = 1'b1; c.done = 1'b1; end
            MEMWRITE: begin c.iorD = 1'b1; c.memWrite = 1'b1; end
            EXECUTE:  begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
            ALUWB:    begin c.regDst = 1'b1; c.regWrite = 1'b1; c.done = 1'b1; end
            BRANCH:   begin
                c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcSrc = 2'b01;
                c.branch = 1'b1; c.done = 1'b1;
            end
            ADDIEX:   begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            ADDIWB:   begin c.regWrite = 1'b1; c.done = 1'b1; end
            JUMP:     begin c.pcSrc = 2'b10; c.pcWrite = 1'b1; c.done = 1'b1; end
            ILLEGAL:  c.illegalOp = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:    nxt = mr ? DECODE : FETCH;
            DECODE: begin
                if (op6 == 6'b100011 || op6 == 6'b101011) nxt = MEMADR;
                else if (op6 == 6'b000000)                nxt = EXECUTE;
                else if (op6 == 6'b000100)                nxt = BRANCH;
                else if (op6 == 6'b001000 && SUPPORT_ADDI != 0) nxt = ADDIEX;
                else if (op6 == 6'b000010 && SUPPORT_JUMP != 0) nxt = JUMP;
                else                                      nxt = ILLEGAL;
            end
            MEMADR:   nxt = (op6 == 6'b100011) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = mr ? MEMWB : MEMREAD;
            MEMWRITE: nxt = mr ? FETCH : MEMWRITE;
            EXECUTE:  nxt = ALUWB;
            ADDIEX:   nxt = ADDIWB;
            default:  nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= FETCH;
            ctl        <= decode(FETCH);
            instrCount <= '0;
        end else begin
            st  <= nxt;
            ctl <= decode(nxt);
            if (instrDone) instrCount <= instrCount + CNT_WIDTH'(1);
        end
    end

    // Enables are masked by rst_n so a reset aborts any write in flight.
    assign pcWrite   = rst_n & (ctl.pcWrite | (ctl.fetch & mr));
    assign irWrite   = rst_n & ctl.fetch & mr;
    assign memWrite  = rst_n & ctl.memWrite;
    assign regWrite  = rst_n & ctl.regWrite;
    assign branch    = rst_n & ctl.branch;
    assign instrDone = rst_n & (ctl.done | (ctl.memWrite & mr));
    assign iorD      = ctl.iorD;
    assign regDst    = ctl.regDst;
    assign memToReg  = ctl.memToReg;
    assign aluSrcA   = ctl.aluSrcA;
    assign aluSrcB   = ctl.aluSrcB;
    assign pcSrc     = ctl.pcSrc;
    assign aluOp     = ctl.aluOp;
    assign illegalOp = ctl.illegalOp;
    assign state     = st;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction expected state
// traces and a per-state control table, checked every cycle on two configs.
module tb_multicycle_controller;
    logic clk = 1'b0, rst_n = 1'b0, memReady = 1'b0;
    logic [5:0] Op = '0;
    int checks = 0, errors = 0, modCnt = 0;
    bit sel = 1'b0;  // 0: default config, 1: no-ADDI, 2-bit counter

    logic pwA, irA, mwA, rwA, brA, iorA, rdA, m2rA, saA, illA, dnA;
    logic [1:0] sbA, psA, aoA; logic [3:0] stA; logic [15:0] cntA;
    logic pwB, irB, mwB, rwB, brB, iorB, rdB, m2rB, saB, illB, dnB;
    logic [1:0] sbB, psB, aoB; logic [3:0] stB; logic [1:0] cntB;
    logic [16:0] ctlA, ctlB;

    always #5 clk = ~clk;

    multicycle_controller dutA (
        .clk(clk), .rst_n(rst_n), .Op(Op), .memReady(memReady),
        .pcWrite(pwA), .irWrite(irA), .memWrite(mwA), .regWrite(rwA), .branch(brA),
        .iorD(iorA), .regDst(rdA), .memToReg(m2rA), .aluSrcA(saA), .aluSrcB(sbA),
        .pcSrc(psA), .aluOp(aoA), .state(stA), .illegalOp(illA), .instrDone(dnA),
        .instrCount(cntA));

    multicycle_controller #(.SUPPORT_ADDI(0), .CNT_WIDTH(2)) dutB (
        .clk(clk), .rst_n(rst_n), .Op(Op), .memReady(memReady),
        .pcWrite(pwB), .irWrite(irB), .memWrite(mwB), .regWrite(rwB), .branch(brB),
        .iorD(iorB), .regDst(rdB), .memToReg(m2rB), .aluSrcA(saB), .aluSrcB(sbB),
        .pcSrc(psB), .aluOp(aoB), .state(stB), .illegalOp(illB), .instrDone(dnB),
        .instrCount(cntB));

    assign ctlA = {pwA, irA, mwA, rwA, brA, iorA, rdA, m2rA, saA, sbA, psA, aoA, illA, dnA};
    assign ctlB = {pwB, irB, mwB, rwB, brB, iorB, rdB, m2rB, saB, sbB, psB, aoB, illB, dnB};

    // Control table straight from the state descriptions.
    function automatic logic [16:0] expCtl(int s, bit mr, bit rstn);
        logic pw, ir, mw, rw, br, io, rd, m2r, sa, ill, dn;
        logic [1:0] sb, ps, ao;
        {pw, ir, mw, rw, br, io, rd, m2r, sa, ill, dn} = '0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        case (s)
            0:  begin sb = 2'b01; pw = mr; ir = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; dn = 1; end
            5:  begin io = 1; mw = 1; dn = mr; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; dn = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; dn = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; dn = 1; end
            11: begin ps = 2'b10; pw = 1; dn = 1; end
            12: ill = 1;
            default: ;
        endcase
        if (!rstn) {pw, ir, mw, rw, br, dn} = '0;
        return {pw, ir, mw, rw, br, io, rd, m2r, sa, sb, ps, ao, ill, dn};
    endfunction

    task automatic checkNow(string name, int i, int expSt, bit mr, bit rstn);
        logic [3:0]  gotSt;
        logic [16:0] gotCtl, wantCtl;
        logic [15:0] gotCnt, wantCnt;
        gotSt   = sel ? stB : stA;
        gotCtl  = sel ? ctlB : ctlA;
        gotCnt  = sel ? {14'b0, cntB} : cntA;
        wantCtl = expCtl(expSt, mr, rstn);
        wantCnt = 16'(modCnt) & (sel ? 16'h3 : 16'hFFFF);
        checks += 3;
        if (gotSt !== 4'(expSt)) begin
            errors++;
            $display("FAIL %s state cyc%0d: got %0d expected %0d", name, i, gotSt, expSt);
        end
        if (gotCtl !== wantCtl) begin
            errors++;
            $display("FAIL %s ctl cyc%0d st%0d: got %b expected %b", name, i, expSt, gotCtl, wantCtl);
        end
        if (gotCnt !== wantCnt) begin
            errors++;
            $display("FAIL %s instrCount cyc%0d: got %0d expected %0d", name, i, gotCnt, wantCnt);
        end
    endtask

    // Runs one instruction from FETCH with f fetch stalls and m memory stalls;
    // abortAt >= 0 asserts reset during that cycle of the instruction.
    task automatic runInstr(string name, logic [5:0] op, int f, int m, int abortAt);
        int stq[$]; bit mrq[$];
        for (int i = 0; i <= f; i++) begin stq.push_back(0); mrq.push_back(i == f); end
        stq.push_back(1); mrq.push_back(1'($urandom));
        case (op)
            6'h23: begin
                stq.push_back(2); mrq.push_back(1'($urandom));
                for (int i = 0; i <= m; i++) begin stq.push_back(3); mrq.push_back(i == m); end
                stq.push_back(4); mrq.push_back(1'($urandom));
            end
            6'h2B: begin
                stq.push_back(2); mrq.push_back(1'($urandom));
                for (int i = 0; i <= m; i++) begin stq.push_back(5); mrq.push_back(i == m); end
            end
            6'h00: begin stq.push_back(6); stq.push_back(7); mrq.push_back(1); mrq.push_back(0); end
            6'h04: begin stq.push_back(8); mrq.push_back(1'($urandom)); end
            6'h08: begin
                if (sel) begin stq.push_back(12); mrq.push_back(1); end
                else begin stq.push_back(9); stq.push_back(10); mrq.push_back(0); mrq.push_back(1); end
            end
            6'h02: begin stq.push_back(11); mrq.push_back(1'($urandom)); end
            default: begin stq.push_back(12); mrq.push_back(1'($urandom)); end
        endcase
        for (int i = 0; i < stq.size(); i++) begin
            @(negedge clk);
            if (i == 0) Op = op;
            memReady = mrq[i];
            #1;
            checkNow(name, i, stq[i], mrq[i], 1'b1);
            if (i == abortAt) begin
                rst_n = 1'b0;
                modCnt = 0;
                #1;
                checkNow({name, "_abort"}, i, 0, mrq[i], 1'b0);
                return;
            end
            if (expCtl(stq[i], mrq[i], 1'b1) & 17'h1) modCnt++;
        end
    endtask

    task automatic releaseRst;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic pulseRst;
        @(negedge clk); rst_n = 1'b0; modCnt = 0;
        releaseRst();
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        memReady = 1'b1; #1; checkNow("reset_mr1", 0, 0, 1'b1, 1'b0);
        memReady = 1'b0; #1; checkNow("reset_mr0", 0, 0, 1'b0, 1'b0);
        releaseRst();
    endtask

    task automatic test_directed;
        runInstr("rtype", 6'h00, 0, 0, -1);
        runInstr("lw_stall2", 6'h23, 0, 2, -1);
        runInstr("sw_stall1", 6'h2B, 0, 1, -1);
        runInstr("beq", 6'h04, 0, 0, -1);
        runInstr("j", 6'h02, 0, 0, -1);
        runInstr("addi", 6'h08, 1, 0, -1);
        runInstr("illegal", 6'h16, 2, 0, -1);
    endtask

    task automatic test_random;
        logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            int k = int'($urandom_range(0, 6));
            op = (k == 6) ? 6'($urandom) : ops[k];
            runInstr("random", op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
        end
    endtask

    task automatic test_reset_mid;
        runInstr("lw_abort", 6'h23, 0, 0, 4);
        releaseRst();
        runInstr("after_abort", 6'h00, 0, 0, -1);
    endtask

    task automatic test_no_addi;
        sel = 1'b1;
        pulseRst();
        runInstr("noaddi_illegal", 6'h16, 0, 0, -1);
        runInstr("noaddi_addi", 6'h08, 0, 0, -1);
    endtask

    task automatic test_wrap;
        sel = 1'b1;
        pulseRst();
        for (int n = 0; n < 5; n++) runInstr("wrap", 6'h00, 0, 0, -1);
        @(negedge clk); #1;
        checks++;
        if (cntB !== 2'd1) begin
            errors++;
            $display("FAIL wrap_final: got %0d expected 1", cntB);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_no_addi();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
